stopwatch_ctrl: RTL

Run/pause/clear controller that sequences the two-digit BCD count feeding display_mux (in_uni/in_dec).
- Conditions three push-buttons.
- Runs a prescaler to generate count ticks only while running.
- Maintains a wrap-around BCD count.
- Optionally freezes the displayed value for lap timing while counting continues.

---
 rtl/stopwatch_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller producing the two-digit BCD count for display_mux.
// Define LAP_EN to compile in the lap-freeze of the displayed digits.
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV    = 1000,
   parameter int unsigned MAX_VAL     = 99,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_clr,
   input  logic       btn_lap,
   output logic [3:0] dig_uni,
   output logic [3:0] dig_dec,
   output logic       running,
   output logic       tick_o,
   output logic       wrap
);

   localparam int unsigned     PreW    = $clog2(TICK_DIV);
   localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
   localparam logic [PreW-1:0] PreOne  = PreW'(1);
   localparam logic [3:0]      MaxUni  = 4'(MAX_VAL % 10);
   localparam logic [3:0]      MaxDec  = 4'(MAX_VAL / 10);

   localparam int unsigned BtnSs  = 0;
   localparam int unsigned BtnClr = 1;
`ifdef LAP_EN
   localparam int unsigned BtnLap = 2;
   localparam int unsigned NumBtn = 3;
`else
   localparam int unsigned NumBtn = 2;
`endif

   typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

   logic [NumBtn-1:0] btn_raw;
`ifdef LAP_EN
   assign btn_raw = {btn_lap, btn_clr, btn_ss};
`else
   logic unused_btn_lap;
   assign unused_btn_lap = btn_lap;
   assign btn_raw        = {btn_clr, btn_ss};
`endif

   // ---------------------------------------------------------------- buttons
   logic [NumBtn-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES-1:0]             vld_q, vld_d;
   logic [NumBtn-1:0]                  sync_last;
   logic [NumBtn-1:0]                  prev_q, prev_d;
   logic [NumBtn-1:0]                  arm_q, arm_d;
   logic [NumBtn-1:0]                  pulse_q, pulse_d;

   // vld_q marks when the sync chain holds real post-reset samples; a button only
   // arms after one of those samples is low, so a press held through reset is ignored.
   always_comb begin
      sync_d    = sync_q;
      sync_last = '0;
      for (int b = 0; b < NumBtn; b++) begin
         sync_d[b]    = {sync_q[b][SYNC_STAGES-2:0], btn_raw[b]};
         sync_last[b] = sync_q[b][SYNC_STAGES-1];
      end
      vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
      prev_d  = sync_last;
      arm_d   = arm_q | ({NumBtn{vld_q[SYNC_STAGES-1]}} & ~sync_last);
      pulse_d = sync_last & ~prev_q & arm_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         vld_q   <= '0;
         prev_q  <= '0;
         arm_q   <= '0;
         pulse_q <= '0;
      end else begin
         sync_q  <= sync_d;
         vld_q   <= vld_d;
         prev_q  <= prev_d;
         arm_q   <= arm_d;
         pulse_q <= pulse_d;
      end
   end

   logic p_ss, p_clr;
   assign p_ss  = pulse_q[BtnSs];
   assign p_clr = pulse_q[BtnClr];
`ifdef LAP_EN
   logic p_lap;
   assign p_lap = pulse_q[BtnLap];
`endif

   // ---------------------------------------------------------- control/count
   state_e          state_q, state_d;
   logic [PreW-1:0] presc_q, presc_d;
   logic [3:0]      uni_q, uni_d, dec_q, dec_d;
   logic [3:0]      dig_uni_q, dig_uni_d, dig_dec_q, dig_dec_d;
   logic            wrap_q, wrap_d;
   logic            running_q, running_d;
   logic            tick;
   logic            hold;
`ifdef LAP_EN
   logic            lap_q, lap_d;
`endif

   always_comb begin
      state_d = state_q;
      if (p_clr) begin
         state_d = StIdle;
      end else if (p_ss) begin
         unique case (state_q)
            StIdle:  state_d = StRun;
            StRun:   state_d = StPause;
            StPause: state_d = StRun;
            default: state_d = StIdle;
         endcase
      end
      running_d = (state_d == StRun);
   end

   assign tick = (state_q == StRun) && (presc_q == PreLast);

   always_comb begin
      presc_d = presc_q;
      if (p_clr) begin
         presc_d = '0;
      end else if (state_q == StRun) begin
         presc_d = tick ? '0 : presc_q + PreOne;
      end
   end

   // Clear outranks a coincident tick, so no wrap pulse can accompany a clear.
   always_comb begin
      uni_d  = uni_q;
      dec_d  = dec_q;
      wrap_d = 1'b0;
      if (p_clr) begin
         uni_d = '0;
         dec_d = '0;
      end else if (tick) begin
         if ((uni_q == MaxUni) && (dec_q == MaxDec)) begin
            uni_d  = '0;
            dec_d  = '0;
            wrap_d = 1'b1;
         end else if (uni_q == 4'd9) begin
            uni_d = '0;
            dec_d = dec_q + 4'd1;
         end else begin
            uni_d = uni_q + 4'd1;
         end
      end
   end

`ifdef LAP_EN
   always_comb begin
      lap_d = lap_q;
      if (p_clr) begin
         lap_d = 1'b0;
      end else if (p_lap && (state_q == StRun)) begin
         lap_d = ~lap_q;
      end
   end
   assign hold = lap_q;
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      dig_uni_d = hold ? dig_uni_q : uni_q;
      dig_dec_d = hold ? dig_dec_q : dec_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         uni_q     <= '0;
         dec_q     <= '0;
         wrap_q    <= 1'b0;
         running_q <= 1'b0;
         dig_uni_q <= '0;
         dig_dec_q <= '0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         uni_q     <= uni_d;
         dec_q     <= dec_d;
         wrap_q    <= wrap_d;
         running_q <= running_d;
         dig_uni_q <= dig_uni_d;
         dig_dec_q <= dig_dec_d;
      end
   end

`ifdef LAP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         lap_q <= 1'b0;
      end else begin
         lap_q <= lap_d;
      end
   end
`endif

   assign dig_uni = dig_uni_q;
   assign dig_dec = dig_dec_q;
   assign running = running_q;
   assign tick_o  = tick;
   assign wrap    = wrap_q;

endmodule
